// File: rtl/adr_pkg.sv
// Shared types and constants for the pipelined load/store address generator.
// Entry layout gains a bnd bit when ADR_BOUND_CHK_EN is defined.
package adr_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int TAG_W_DEF  = 4;

  localparam logic ADR_LD = 1'b0;
  localparam logic ADR_ST = 1'b1;

  // Queue entry at default widths; the top packs fields in this same order.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic                  ovf;
    logic                  st;
    logic [TAG_W_DEF-1:0]  tag;
`ifdef ADR_BOUND_CHK_EN
    logic                  bnd;
`endif
  } adr_entry_t;

endpackage

// File: rtl/adr_fifo.sv
// Generic DEPTH-entry register FIFO with push/pop/flush and occupancy count.
// Storage is not reset; the head output is forced to 0 while empty.
module adr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adr_gen_pipe.sv
// Pipelined effective-address generator: add + overflow on the input side, results
// queued in order for the memory stage. ADR_BOUND_CHK_EN adds the out_bnd limit flag.
module adr_gen_pipe
  import adr_pkg::*;
#(
  parameter int                 ADDR_W     = ADDR_W_DEF,
  parameter int                 TAG_W      = TAG_W_DEF,
  parameter int                 DEPTH      = 2,
  parameter logic [ADDR_W-1:0]  ADDR_LIMIT = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [ADDR_W-1:0]        in_op1,
  input  logic [ADDR_W-1:0]        in_op2,
  input  logic                     in_st,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     out_st,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_ovf,
`ifdef ADR_BOUND_CHK_EN
  output logic                     out_bnd,
`endif
  output logic [$clog2(DEPTH):0]   count
);

`ifdef ADR_BOUND_CHK_EN
  localparam int EW = ADDR_W + 2 + TAG_W + 1;
`else
  localparam int EW = ADDR_W + 2 + TAG_W;
`endif

  logic [ADDR_W:0] sum;
  logic [EW-1:0]   din;
  logic [EW-1:0]   dout;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign sum = {1'b0, in_op1} + {1'b0, in_op2};

`ifdef ADR_BOUND_CHK_EN
  logic bnd;
  assign bnd = sum[ADDR_W] | (sum[ADDR_W-1:0] > ADDR_LIMIT);
  assign din = {sum[ADDR_W-1:0], sum[ADDR_W], in_st, in_tag, bnd};
  assign {out_addr, out_ovf, out_st, out_tag, out_bnd} = dout;
`else
  logic unused_limit;
  assign unused_limit = ^ADDR_LIMIT;
  assign din = {sum[ADDR_W-1:0], sum[ADDR_W], in_st, in_tag};
  assign {out_addr, out_ovf, out_st, out_tag} = dout;
`endif

  // in_rdy depends only on registered occupancy, never on out_rdy.
  assign in_rdy  = ~full & ~rst;
  assign out_vld = ~empty;
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  adr_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_adr_gen_pipe.sv
// Scoreboard bench for adr_gen_pipe: expected entries queued on accept, compared on pop.
module tb_adr_gen_pipe;
  import adr_pkg::*;

  localparam int AW    = ADDR_W_DEF;
  localparam int TW    = TAG_W_DEF;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] LIM = 16'h7FFF;

  logic clk = 1'b0;
  logic rst, flush, in_vld, in_rdy, in_st, out_vld, out_rdy, out_st, out_ovf;
  logic [AW-1:0] in_op1, in_op2, out_addr;
  logic [TW-1:0] in_tag, out_tag;
  logic [CW-1:0] count;
`ifdef ADR_BOUND_CHK_EN
  logic out_bnd;
`endif

  adr_gen_pipe #(.ADDR_W(AW), .TAG_W(TW), .DEPTH(DEPTH), .ADDR_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_op1(in_op1), .in_op2(in_op2),
    .in_st(in_st), .in_tag(in_tag),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_addr(out_addr), .out_st(out_st),
    .out_tag(out_tag), .out_ovf(out_ovf),
`ifdef ADR_BOUND_CHK_EN
    .out_bnd(out_bnd),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  adr_entry_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One cycle: evaluate handshakes at the negedge against the model, then cross the posedge.
  task automatic step(output logic acc);
    adr_entry_t e, h;
    logic [AW:0] s;
    logic rdy_exp;
    @(negedge clk);
    acc = 1'b0;
    if (!rst) begin
      rdy_exp = (sb.size() != DEPTH);
      check("in_rdy", in_rdy, rdy_exp);
      check("out_vld", out_vld, sb.size() != 0);
      check("count", count, sb.size());
      if (sb.size() == 0) check("idle_addr", out_addr, 0);
      if (flush) sb.delete();
      else begin
        if (sb.size() != 0 && out_rdy) begin
          h = sb.pop_front();
          check("out_addr", out_addr, h.addr);
          check("out_ovf", out_ovf, h.ovf);
          check("out_st", out_st, h.st);
          check("out_tag", out_tag, h.tag);
`ifdef ADR_BOUND_CHK_EN
          check("out_bnd", out_bnd, h.bnd);
`endif
        end
        if (in_vld && rdy_exp) begin
          s = {1'b0, in_op1} + {1'b0, in_op2};
          e.addr = s[AW-1:0];
          e.ovf  = s[AW];
          e.st   = in_st;
          e.tag  = in_tag;
`ifdef ADR_BOUND_CHK_EN
          e.bnd  = s[AW] | (s[AW-1:0] > LIM);
`endif
          sb.push_back(e);
          acc = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) step(a);
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic st, input logic [TW-1:0] tag);
    logic acc;
    in_op1 = a; in_op2 = b; in_st = st; in_tag = tag; in_vld = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(acc);
    check("send_accept", acc, 1'b1);
    in_vld = 1'b0;
  endtask

  initial begin
    logic acc;
    rst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    in_op1 = '0; in_op2 = '0; in_st = ADR_LD; in_tag = '0;
    #1;
    check("rst_out_vld", out_vld, 0);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_count", count, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // single op, then wrap with carry
    out_rdy = 1'b1;
    send(16'h1000, 16'h0024, ADR_ST, 4'd3);
    check("single_head_addr", out_addr, 16'h1024);
    idle(2);
    send(16'hFFF0, 16'h0020, ADR_LD, 4'd5);
    check("wrap_head_addr", out_addr, 16'h0010);
    check("wrap_head_ovf", out_ovf, 1);
    send(16'h7FFF, 16'h0000, ADR_LD, 4'd6);
    idle(2);

    // backpressure: third op held until the queue drains
    out_rdy = 1'b0;
    send(16'h0100, 16'h0001, ADR_LD, 4'd0);
    send(16'h0200, 16'h0002, ADR_ST, 4'd1);
    in_op1 = 16'h0300; in_op2 = 16'h0003; in_st = ADR_LD; in_tag = 4'd2; in_vld = 1'b1;
    repeat (3) begin
      step(acc);
      check("bp_held", acc, 0);
    end
    check("bp_count", count, 2);
    check("bp_in_rdy", in_rdy, 0);
    out_rdy = 1'b1;
    send(16'h0300, 16'h0003, ADR_LD, 4'd2);
    idle(4);
    check("bp_drained", sb.size(), 0);

    // streaming: one accept per cycle, count held at 1
    for (int i = 0; i < 10; i++) begin
      in_op1 = 16'($urandom); in_op2 = 16'($urandom);
      in_st = 1'($urandom); in_tag = 4'(i); in_vld = 1'b1;
      step(acc);
      check("stream_acc", acc, 1);
    end
    in_vld = 1'b0;
    check("stream_count", count, 1);
    idle(3);

    // flush with a push in the same cycle
    out_rdy = 1'b0;
    send(16'h0A00, 16'h000A, ADR_ST, 4'd7);
    send(16'h0B00, 16'h000B, ADR_ST, 4'd8);
    flush = 1'b1;
    in_op1 = 16'h0C00; in_op2 = 16'h000C; in_tag = 4'hF; in_vld = 1'b1;
    step(acc);
    flush = 1'b0; in_vld = 1'b0;
    check("flush_count", count, 0);
    check("flush_out_vld", out_vld, 0);
    out_rdy = 1'b1;
    idle(3);

    // async reset mid-stream with a full queue
    out_rdy = 1'b0;
    send(16'h0D00, 16'h000D, ADR_LD, 4'd9);
    send(16'h0E00, 16'h000E, ADR_LD, 4'd10);
    check("pre_rst_count", count, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_out_vld", out_vld, 0);
    check("arst_count", count, 0);
    check("arst_in_rdy", in_rdy, 0);
    check("arst_out_addr", out_addr, 0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_rdy = 1'b1;
    #1;
    check("post_rst_in_rdy", in_rdy, 1);
    idle(3);
    send(16'h2000, 16'h0002, ADR_ST, 4'd4);
    idle(2);
    check("final_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
